mem_arbiter: RTL and testbench
==============================

Name: mem_arbiter

Overview:
- Shares the single-port data/instruction RAM, including its memory-mapped UART window, between two requesters: instruction fetch (ifetch) and load/store unit (lsu).
- Round-robin arbitration with a combinational grant.
- Read responses are registered: data is returned one cycle after grant.
- Sits between the core's fetch/LSU stages and the ram instance, and drives all ram control inputs.

Parameters:
- ADDRESS_WIDTH, 12, byte address width; matches the ram.
- WIDTH, 32, data word width.
- SW_FUNCT3, 3'b010, funct3 presented to the ram for ifetch cycles; the ram ignores it when write_enable is 0.

Ports:
- rst  input  1  synchronous active-high reset
- clk  input  1  single clock; all state on posedge
- ifetch_req  input  1  fetch read request
- ifetch_addr  input  ADDRESS_WIDTH  fetch byte address
- ifetch_gnt  output  1  fetch request accepted this cycle
- ifetch_rvalid  output  1  fetch data valid (cycle after gnt)
- ifetch_rdata  output  WIDTH  fetch read data
- lsu_req  input  1  load/store request
- lsu_we  input  1  1 = store, 0 = load
- lsu_addr  input  ADDRESS_WIDTH  load/store byte address
- lsu_wdata  input  WIDTH  store data
- lsu_funct3  input  3  store width code (SB/SH/SW)
- lsu_gnt  output  1  lsu request accepted this cycle
- lsu_rvalid  output  1  load data valid (cycle after gnt; never for stores)
- lsu_rdata  output  WIDTH  load read data
- ram_write_enable  output  1  to ram write_enable
- ram_read_addr  output  ADDRESS_WIDTH  to ram read_addr
- ram_write_addr  output  ADDRESS_WIDTH  to ram write_addr
- ram_data_in  output  WIDTH  to ram data_in
- ram_store_funct3  output  3  to ram store_funct3
- ram_data_out  input  WIDTH  from ram data_out (combinational read)

Behaviour:
Reset values (while rst = 1):
- gnt outputs forced 0.
- rvalid flops 0; rdata flops 0.
- last_grant = IFETCH, so lsu wins the first conflict.
- ram_write_enable = 0.

Arbitration (combinational, every cycle):
- Only one requester asserts req: it is granted.
- Both assert req: grant goes to the requester that is not last_grant.
- Neither asserts req: no grant; ram_write_enable = 0; ram addresses = ifetch_addr (don't-care).
- At most one gnt is high in any cycle.
- last_grant updates on posedge only when a grant occurred.

Handshake:
- req/addr/wdata/we/funct3 must be held stable until gnt is sampled high.
- A transfer completes at the posedge where req && gnt.
- A requester may deassert req without a grant; no side effects.
- Back-to-back grants to the same requester are allowed when the other is idle (pipelined: gnt in cycle N and N+1 give rvalid in N+1 and N+2).

Ram drive:
- Granted owner's address goes to both ram_read_addr and ram_write_addr.
- ram_write_enable = lsu_gnt && lsu_we.
- ram_data_in = lsu_wdata.
- ram_store_funct3 = lsu_funct3 when lsu owns the ram, else SW_FUNCT3.

Response:
- At a granted read, ram_data_out is captured into the owner's rdata register.
- The owner's rvalid is 1 for exactly the next cycle.
- rdata holds its value until the next read by the same owner.
- Stores produce no rvalid.

Boundaries:
- Sustained dual requests alternate strictly (L, I, L, I...), so neither starves.
- Reads at the UART address are treated like any other read; the status value is captured in the grant cycle.
- rst asserted mid-operation: a pending rvalid is dropped the next cycle, and no write is issued while rst = 1.

Decomposition:
- Shared package: funct3 constants (SB = 000, SH = 001, SW = 010), the owner encoding (IFETCH = 0, LSU = 1) and the UART offset constant, all shared with the ram and the core.
- Natural sub-module: rr_arbiter2, a 2-way round-robin grant with a last_grant flop.
- Response registers stay in mem_arbiter.

Test Plan:
- Reset: hold rst 3 cycles with both req = 1 -> both gnt = 0, both rvalid = 0, ram_write_enable = 0. First cycle after release -> lsu_gnt = 1, ifetch_gnt = 0.
- Fetch only: ifetch_req at addr 0x010, mem word 4 = 0xDEADBEEF -> ifetch_gnt same cycle; ifetch_rvalid = 1 and ifetch_rdata = 0xDEADBEEF next cycle, for 1 cycle only.
- Store then load: lsu SB of 0xA5 to 0x021, then load 0x020 (word preloaded 0x11223344) -> store gives no rvalid; load returns 0x1122A544 with lsu_rvalid.
- Contention: both req held 6 cycles -> grants L, I, L, I, L, I. Each read's rvalid follows its own grant by exactly 1 cycle; never both gnt in one cycle.
- Reset mid-read: grant ifetch, assert rst the next cycle -> ifetch_rvalid = 0 during rst; no ram write while rst = 1.
- UART path: lsu SW of 0x00004101 to the UART base, then load the UART base -> lsu_rdata[15:8] = 0x41 and [0] = 1 one cycle after the load grant.

Source files
------------

// File: rtl/mem_arbiter_pkg.sv
// Shared constants for the RAM, its UART window and the requesters around it.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package mem_arbiter_pkg;

    localparam logic [2:0] FUNCT3_SB = 3'b000;
    localparam logic [2:0] FUNCT3_SH = 3'b001;
    localparam logic [2:0] FUNCT3_SW = 3'b010;

    // Byte offset of the memory-mapped UART window inside the RAM address space.
    localparam logic [11:0] UART_OFFSET = 12'hF00;

    typedef enum logic {
        OWNER_IFETCH = 1'b0,
        OWNER_LSU    = 1'b1
    } owner_e;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin grant; bit 0 = ifetch, bit 1 = lsu.
// Latency: grant is combinational in the request cycle.
// Backpressure: a loser keeps requesting and wins the next conflict.
module rr_arbiter2
    import mem_arbiter_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    output logic [1:0] gnt
);

    owner_e last_grant;

    always_comb begin
        gnt = 2'b00;
        if (!rst) begin
            if (req == 2'b11) begin
                gnt = (last_grant == OWNER_IFETCH) ? 2'b10 : 2'b01;
            end else begin
                gnt = req;
            end
        end
    end

    // Starts at IFETCH so the lsu wins the first conflict after reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            last_grant <= OWNER_IFETCH;
        end else if (gnt != 2'b00) begin
            last_grant <= gnt[1] ? OWNER_LSU : OWNER_IFETCH;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Shares the single-port RAM (and its UART window) between ifetch and lsu.
// Latency: combinational grant, read data returned one cycle after grant.
// Backpressure: an ungranted requester holds req and its payload until gnt.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int          ADDRESS_WIDTH = 12,
    parameter int          WIDTH         = 32,
    parameter logic [2:0]  SW_FUNCT3     = FUNCT3_SW
) (
    input  logic                     rst,
    input  logic                     clk,
    input  logic                     ifetch_req,
    input  logic [ADDRESS_WIDTH-1:0] ifetch_addr,
    output logic                     ifetch_gnt,
    output logic                     ifetch_rvalid,
    output logic [WIDTH-1:0]         ifetch_rdata,
    input  logic                     lsu_req,
    input  logic                     lsu_we,
    input  logic [ADDRESS_WIDTH-1:0] lsu_addr,
    input  logic [WIDTH-1:0]         lsu_wdata,
    input  logic [2:0]               lsu_funct3,
    output logic                     lsu_gnt,
    output logic                     lsu_rvalid,
    output logic [WIDTH-1:0]         lsu_rdata,
    output logic                     ram_write_enable,
    output logic [ADDRESS_WIDTH-1:0] ram_read_addr,
    output logic [ADDRESS_WIDTH-1:0] ram_write_addr,
    output logic [WIDTH-1:0]         ram_data_in,
    output logic [2:0]               ram_store_funct3,
    input  logic [WIDTH-1:0]         ram_data_out
);

    logic [1:0]               gnt;
    owner_e                   owner;
    logic [ADDRESS_WIDTH-1:0] ram_addr;
    logic                     lsu_read;
    logic                     ifetch_rvalid_q;
    logic                     lsu_rvalid_q;

    rr_arbiter2 u_rr_arbiter2 (
        .clk (clk),
        .rst (rst),
        .req ({lsu_req, ifetch_req}),
        .gnt (gnt)
    );

    assign ifetch_gnt = gnt[0];
    assign lsu_gnt    = gnt[1];

    // With no grant the ram still sees ifetch_addr; the read result is ignored.
    assign owner    = lsu_gnt ? OWNER_LSU : OWNER_IFETCH;
    assign ram_addr = (owner == OWNER_LSU) ? lsu_addr : ifetch_addr;

    assign ram_read_addr    = ram_addr;
    assign ram_write_addr   = ram_addr;
    assign ram_write_enable = lsu_gnt && lsu_we;
    assign ram_data_in      = lsu_wdata;
    assign ram_store_funct3 = (owner == OWNER_LSU) ? lsu_funct3 : SW_FUNCT3;

    assign lsu_read = lsu_gnt && !lsu_we;

    always_ff @(posedge clk) begin
        if (rst) begin
            ifetch_rvalid_q <= 1'b0;
            lsu_rvalid_q    <= 1'b0;
            ifetch_rdata    <= '0;
            lsu_rdata       <= '0;
        end else begin
            ifetch_rvalid_q <= ifetch_gnt;
            lsu_rvalid_q    <= lsu_read;
            if (ifetch_gnt) begin
                ifetch_rdata <= ram_data_out;
            end
            if (lsu_read) begin
                lsu_rdata <= ram_data_out;
            end
        end
    end

    // A response still in flight when rst rises is never presented.
    assign ifetch_rvalid = ifetch_rvalid_q && !rst;
    assign lsu_rvalid    = lsu_rvalid_q && !rst;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter with a behavioural RAM + UART stub and a reference model.
module tb_mem_arbiter;
    import mem_arbiter_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        ifetch_req;
    logic [11:0] ifetch_addr;
    logic        ifetch_gnt, ifetch_rvalid;
    logic [31:0] ifetch_rdata;
    logic        lsu_req, lsu_we;
    logic [11:0] lsu_addr;
    logic [31:0] lsu_wdata;
    logic [2:0]  lsu_funct3;
    logic        lsu_gnt, lsu_rvalid;
    logic [31:0] lsu_rdata;
    logic        ram_write_enable;
    logic [11:0] ram_read_addr, ram_write_addr;
    logic [31:0] ram_data_in;
    logic [2:0]  ram_store_funct3;
    logic [31:0] ram_data_out;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    mem_arbiter #(.ADDRESS_WIDTH(12), .WIDTH(32), .SW_FUNCT3(FUNCT3_SW)) dut (
        .rst(rst), .clk(clk),
        .ifetch_req(ifetch_req), .ifetch_addr(ifetch_addr), .ifetch_gnt(ifetch_gnt),
        .ifetch_rvalid(ifetch_rvalid), .ifetch_rdata(ifetch_rdata),
        .lsu_req(lsu_req), .lsu_we(lsu_we), .lsu_addr(lsu_addr), .lsu_wdata(lsu_wdata),
        .lsu_funct3(lsu_funct3), .lsu_gnt(lsu_gnt), .lsu_rvalid(lsu_rvalid), .lsu_rdata(lsu_rdata),
        .ram_write_enable(ram_write_enable), .ram_read_addr(ram_read_addr),
        .ram_write_addr(ram_write_addr), .ram_data_in(ram_data_in),
        .ram_store_funct3(ram_store_funct3), .ram_data_out(ram_data_out)
    );

    function automatic logic [31:0] init_word(int i);
        if (i == 4) return 32'hDEADBEEF;
        if (i == 8) return 32'h11223344;
        return 32'hA000_0000 ^ (32'(i) * 32'h0001_0203);
    endfunction

    // ---------------- RAM stub (environment) ----------------
    logic        preload;
    logic [31:0] ram_mem [0:1023];
    logic [31:0] ram_uart;
    logic [4:0]  st_sh;
    logic [31:0] st_mask;

    assign ram_data_out = (ram_read_addr[11:2] == UART_OFFSET[11:2]) ?
                          {16'h0, ram_uart[15:8], 7'h0, 1'b1} : ram_mem[ram_read_addr[11:2]];

    always_comb begin
        st_sh   = 5'd0;
        st_mask = 32'hFFFF_FFFF;
        case (ram_store_funct3)
            FUNCT3_SB: begin st_sh = {ram_write_addr[1:0], 3'b000}; st_mask = 32'h0000_00FF << st_sh; end
            FUNCT3_SH: begin st_sh = {ram_write_addr[1], 4'b0000};  st_mask = 32'h0000_FFFF << st_sh; end
            default: ;
        endcase
    end

    always @(posedge clk) begin
        if (preload) begin
            for (int i = 0; i < 1024; i++) ram_mem[i] <= init_word(i);
            ram_uart <= '0;
        end else if (ram_write_enable) begin
            if (ram_write_addr[11:2] == UART_OFFSET[11:2]) ram_uart <= ram_data_in;
            else ram_mem[ram_write_addr[11:2]] <= (ram_mem[ram_write_addr[11:2]] & ~st_mask) |
                                                  ((ram_data_in << st_sh) & st_mask);
        end
    end

    // ---------------- Reference model ----------------
    logic [31:0] model_mem [0:1023];
    logic [31:0] m_uart;
    bit          m_lsu_last;      // true when the lsu received the most recent grant
    bit          m_irv, m_lrv;
    logic [31:0] m_ird, m_lrd;
    bit          exp_ig, exp_lg;

    function automatic logic [31:0] model_read(logic [11:0] a);
        if (a[11:2] == UART_OFFSET[11:2]) return {16'h0, m_uart[15:8], 7'h0, 1'b1};
        return model_mem[a[11:2]];
    endfunction

    task automatic model_write(input logic [11:0] a, input logic [31:0] d, input logic [2:0] f3);
        logic [31:0] w;
        if (a[11:2] == UART_OFFSET[11:2]) begin
            m_uart = d;
            return;
        end
        w = model_mem[a[11:2]];
        if (f3 == FUNCT3_SB) w[a[1:0]*8 +: 8] = d[7:0];
        else if (f3 == FUNCT3_SH) w[a[1]*16 +: 16] = d[15:0];
        else w = d;
        model_mem[a[11:2]] = w;
    endtask

    // Grant rule: sole requester wins; on conflict the one not served last wins.
    task automatic predict();
        exp_ig = 0;
        exp_lg = 0;
        if (!rst) begin
            if (ifetch_req && lsu_req) begin
                if (m_lsu_last) exp_ig = 1; else exp_lg = 1;
            end else begin
                exp_ig = ifetch_req;
                exp_lg = lsu_req;
            end
        end
    endtask

    // Advance the model across the coming posedge.
    task automatic commit();
        if (rst) begin
            m_irv = 0; m_lrv = 0; m_ird = '0; m_lrd = '0; m_lsu_last = 0;
        end else begin
            m_irv = exp_ig;
            m_lrv = exp_lg && !lsu_we;
            if (exp_ig) m_ird = model_read(ifetch_addr);
            if (exp_lg && !lsu_we) m_lrd = model_read(lsu_addr);
            if (exp_lg && lsu_we) model_write(lsu_addr, lsu_wdata, lsu_funct3);
            if (exp_ig || exp_lg) m_lsu_last = exp_lg;
        end
    endtask

    task automatic drive(input logic r, input logic ir, input logic [11:0] ia, input logic lr,
                         input logic lwe, input logic [11:0] la, input logic [31:0] lwd,
                         input logic [2:0] lf);
        rst = r; ifetch_req = ir; ifetch_addr = ia;
        lsu_req = lr; lsu_we = lwe; lsu_addr = la; lsu_wdata = lwd; lsu_funct3 = lf;
    endtask

    // ---------------- Scenarios ----------------
    task automatic test_reset();
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            preload = 1'b0;
            drive(1, 1, 12'h010, 1, 0, 12'h020, 32'h0, FUNCT3_SW);
            #1; predict();
            checks++;
            if ({ifetch_gnt, lsu_gnt} !== 2'b00) begin
                failures++; $display("FAIL reset_gnt cycle %0d got=%b exp=00", c, {ifetch_gnt, lsu_gnt});
            end
            checks++;
            if ({ifetch_rvalid, lsu_rvalid, ram_write_enable} !== 3'b000) begin
                failures++; $display("FAIL reset_rvalid_we cycle %0d got=%b exp=000", c, {ifetch_rvalid, lsu_rvalid, ram_write_enable});
            end
            commit();
        end
        @(negedge clk);
        rst = 1'b0;
        #1; predict();
        checks++;
        if ({ifetch_gnt, lsu_gnt} !== 2'b01) begin
            failures++; $display("FAIL first_conflict got ig,lg=%b exp=01", {ifetch_gnt, lsu_gnt});
        end
        checks++;
        if ({ifetch_rdata, lsu_rdata} !== 64'h0) begin
            failures++; $display("FAIL reset_rdata got=%h exp=0", {ifetch_rdata, lsu_rdata});
        end
        commit();
    endtask

    task automatic test_fetch_only();
        @(negedge clk);
        drive(0, 1, 12'h010, 0, 0, 12'h0, 32'h0, FUNCT3_SW);
        #1; predict();
        checks++;
        if ({ifetch_gnt, lsu_gnt, ram_read_addr} !== {2'b10, 12'h010}) begin
            failures++; $display("FAIL fetch_gnt got gnt=%b addr=%h exp gnt=10 addr=010", {ifetch_gnt, lsu_gnt}, ram_read_addr);
        end
        commit();
        @(negedge clk);
        drive(0, 0, 12'h010, 0, 0, 12'h0, 32'h0, FUNCT3_SW);
        #1; predict();
        checks++;
        if (ifetch_rvalid !== 1'b1 || ifetch_rdata !== 32'hDEADBEEF) begin
            failures++; $display("FAIL fetch_data got v=%b d=%h exp v=1 d=deadbeef", ifetch_rvalid, ifetch_rdata);
        end
        commit();
        @(negedge clk);
        #1; predict();
        checks++;
        if (ifetch_rvalid !== 1'b0 || ifetch_rdata !== 32'hDEADBEEF) begin
            failures++; $display("FAIL fetch_one_cycle got v=%b d=%h exp v=0 d=deadbeef", ifetch_rvalid, ifetch_rdata);
        end
        commit();
    endtask

    task automatic test_store_load();
        @(negedge clk);
        drive(0, 0, 12'h0, 1, 1, 12'h021, 32'h0000_00A5, FUNCT3_SB);
        #1; predict();
        checks++;
        if ({lsu_gnt, ram_write_enable, ram_store_funct3, ram_write_addr, ram_data_in} !==
            {1'b1, 1'b1, FUNCT3_SB, 12'h021, 32'h0000_00A5}) begin
            failures++; $display("FAIL store_drive got g=%b we=%b f3=%b a=%h d=%h", lsu_gnt,
                                 ram_write_enable, ram_store_funct3, ram_write_addr, ram_data_in);
        end
        commit();
        @(negedge clk);
        drive(0, 0, 12'h0, 1, 0, 12'h020, 32'h0, FUNCT3_SW);
        #1; predict();
        checks++;
        if ({lsu_rvalid, lsu_gnt, ram_write_enable} !== 3'b010) begin
            failures++; $display("FAIL store_no_rvalid got rv,g,we=%b exp=010", {lsu_rvalid, lsu_gnt, ram_write_enable});
        end
        commit();
        @(negedge clk);
        drive(0, 0, 12'h0, 0, 0, 12'h0, 32'h0, FUNCT3_SW);
        #1; predict();
        checks++;
        if (lsu_rvalid !== 1'b1 || lsu_rdata !== 32'h1122A544) begin
            failures++; $display("FAIL store_load got v=%b d=%h exp v=1 d=1122a544", lsu_rvalid, lsu_rdata);
        end
        commit();
    endtask

    task automatic test_contention();
        bit prev_ig = 1, prev_lg = 0;
        @(negedge clk);
        drive(0, 1, 12'h000, 0, 0, 12'h0, 32'h0, FUNCT3_SW);
        #1; predict(); commit();
        for (int k = 0; k <= 6; k++) begin
            @(negedge clk);
            if (k < 6) drive(0, 1, 12'h010, 1, 0, 12'h020, 32'h0, FUNCT3_SW);
            else       drive(0, 0, 12'h010, 0, 0, 12'h020, 32'h0, FUNCT3_SW);
            #1; predict();
            if (k < 6) begin
                checks++;
                if ({ifetch_gnt, lsu_gnt} !== ((k % 2 == 0) ? 2'b01 : 2'b10)) begin
                    failures++; $display("FAIL contention_order k=%0d got ig,lg=%b", k, {ifetch_gnt, lsu_gnt});
                end
            end
            checks++;
            if ({ifetch_rvalid, lsu_rvalid} !== {prev_ig, prev_lg}) begin
                failures++; $display("FAIL contention_rvalid k=%0d got=%b exp=%b", k, {ifetch_rvalid, lsu_rvalid}, {prev_ig, prev_lg});
            end
            checks++;
            if (ifetch_rdata !== m_ird || lsu_rdata !== m_lrd) begin
                failures++; $display("FAIL contention_rdata k=%0d got=%h/%h exp=%h/%h", k, ifetch_rdata, lsu_rdata, m_ird, m_lrd);
            end
            prev_ig = (k < 6) && (k % 2 == 1);
            prev_lg = (k < 6) && (k % 2 == 0);
            commit();
        end
    endtask

    task automatic test_reset_mid_read();
        @(negedge clk);
        drive(0, 1, 12'h010, 0, 0, 12'h0, 32'h0, FUNCT3_SW);
        #1; predict(); commit();
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            drive(1, 0, 12'h010, 1, 1, 12'h030, 32'hCAFE_F00D, FUNCT3_SW);
            #1; predict();
            checks++;
            if ({ifetch_rvalid, ram_write_enable, lsu_gnt} !== 3'b000) begin
                failures++; $display("FAIL reset_mid_read c=%0d got rv,we,lg=%b exp=000", c, {ifetch_rvalid, ram_write_enable, lsu_gnt});
            end
            commit();
        end
        @(negedge clk);
        drive(0, 0, 12'h010, 0, 0, 12'h030, 32'h0, FUNCT3_SW);
        #1; predict();
        checks++;
        if ({ifetch_rvalid, ifetch_rdata} !== 33'h0) begin
            failures++; $display("FAIL reset_mid_read_after got v=%b d=%h exp v=0 d=0", ifetch_rvalid, ifetch_rdata);
        end
        commit();
    endtask

    task automatic test_uart();
        @(negedge clk);
        drive(0, 0, 12'h0, 1, 1, UART_OFFSET, 32'h0000_4101, FUNCT3_SW);
        #1; predict(); commit();
        @(negedge clk);
        drive(0, 0, 12'h0, 1, 0, UART_OFFSET, 32'h0, FUNCT3_SW);
        #1; predict();
        checks++;
        if (lsu_gnt !== 1'b1 || lsu_rvalid !== 1'b0) begin
            failures++; $display("FAIL uart_load_gnt got g=%b rv=%b exp g=1 rv=0", lsu_gnt, lsu_rvalid);
        end
        commit();
        @(negedge clk);
        drive(0, 0, 12'h0, 0, 0, 12'h0, 32'h0, FUNCT3_SW);
        #1; predict();
        checks++;
        if (lsu_rvalid !== 1'b1 || lsu_rdata[15:8] !== 8'h41 || lsu_rdata[0] !== 1'b1) begin
            failures++; $display("FAIL uart_status got v=%b d=%h exp v=1 d[15:8]=41 d[0]=1", lsu_rvalid, lsu_rdata);
        end
        commit();
    endtask

    task automatic test_random();
        logic        ir = 0, lr = 0, lwe = 0;
        logic [11:0] ia = 0, la = 0;
        logic [31:0] lwd = 0;
        logic [2:0]  lf = FUNCT3_SW;
        for (int n = 0; n < 400; n++) begin
            @(negedge clk);
            if (!ir) begin
                ir = 1'($urandom_range(0, 1));
                ia = {4'h0, 6'($urandom_range(0, 63)), 2'b00};
            end
            if (!lr) begin
                lr  = 1'($urandom_range(0, 1));
                lwe = 1'($urandom_range(0, 1));
                la  = 12'($urandom_range(0, 255));
                lwd = $urandom;
                case ($urandom_range(0, 2))
                    0: lf = FUNCT3_SB;
                    1: lf = FUNCT3_SH;
                    default: lf = FUNCT3_SW;
                endcase
            end
            drive(0, ir, ia, lr, lwe, la, lwd, lf);
            #1; predict();
            checks++;
            if ({ifetch_gnt, lsu_gnt, ram_write_enable} !== {exp_ig, exp_lg, exp_lg && lwe}) begin
                failures++; $display("FAIL rand_gnt n=%0d got ig,lg,we=%b exp=%b", n,
                                     {ifetch_gnt, lsu_gnt, ram_write_enable}, {exp_ig, exp_lg, exp_lg && lwe});
            end
            if (exp_ig || exp_lg) begin
                checks++;
                if (ram_read_addr !== (exp_lg ? la : ia) || ram_write_addr !== (exp_lg ? la : ia) ||
                    ram_store_funct3 !== (exp_lg ? lf : FUNCT3_SW)) begin
                    failures++; $display("FAIL rand_ram n=%0d got ra=%h wa=%h f3=%b", n, ram_read_addr, ram_write_addr, ram_store_funct3);
                end
            end
            checks++;
            if ({ifetch_rvalid, lsu_rvalid} !== {m_irv, m_lrv} || ifetch_rdata !== m_ird || lsu_rdata !== m_lrd) begin
                failures++; $display("FAIL rand_resp n=%0d got v=%b %h/%h exp v=%b %h/%h", n, {ifetch_rvalid, lsu_rvalid},
                                     ifetch_rdata, lsu_rdata, {m_irv, m_lrv}, m_ird, m_lrd);
            end
            if (exp_ig) ir = 0;
            if (exp_lg) lr = 0;
            commit();
        end
    endtask

    initial begin
        preload = 1'b1;
        drive(1, 1, 12'h010, 1, 0, 12'h020, 32'h0, FUNCT3_SW);
        for (int i = 0; i < 1024; i++) model_mem[i] = init_word(i);
        m_uart = '0; m_lsu_last = 0; m_irv = 0; m_lrv = 0; m_ird = '0; m_lrd = '0;
        test_reset();
        test_fetch_only();
        test_store_load();
        test_contention();
        test_uart();
        test_reset_mid_read();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
